// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the round-robin ALU arbiter.
// Optional feature macro: ALU_ARB_ILLEGAL_CHECK_EN (flags opcode 011 on rsp_err).
package alu_arb_pkg;

  localparam int ALU_W    = 8;
  // Widest requester ID needed for the largest legal NREQ (8).
  localparam int ID_MAX_W = 3;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
    logic [ALU_W-1:0]    a;
    logic [ALU_W-1:0]    b;
    logic [2:0]          f;
  } s1_t;

  // 011 is the only encoding without an operation behind it.
  function automatic logic alu_op_legal(input logic [2:0] f);
    return (f != 3'b011);
  endfunction

endpackage

// File: rtl/alu8bitsHDL.sv
// Combinational 8-bit ALU shared by all requesters; arithmetic wraps mod 256.
module alu8bitsHDL
  import alu_arb_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       f,
  output logic [ALU_W-1:0] y
);

  // Opcode decode; the illegal encoding falls through to zero.
  always_comb begin
    y = 8'h00;
    case (f)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_ANDN: y = a & ~b;
      ALU_ORN:  y = a | ~b;
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
      default:  y = 8'h00;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker: first set req at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  // Scan NREQ positions starting at ptr; the first requesting one wins.
  always_comb begin
    logic           found_v;
    logic [IDW:0]   sum_v;
    logic [IDW-1:0] sel_v;
    gnt     = '0;
    gnt_idx = '0;
    found_v = 1'b0;
    sum_v   = '0;
    sel_v   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_v = {1'b0, ptr} + (IDW+1)'(i);
      if (sum_v >= (IDW+1)'(NREQ)) begin
        sum_v = sum_v - (IDW+1)'(NREQ);
      end else begin
        sum_v = sum_v;
      end
      sel_v = sum_v[IDW-1:0];
      if (en && !found_v && req[sel_v]) begin
        gnt[sel_v] = 1'b1;
        gnt_idx    = sel_v;
        found_v    = 1'b1;
      end else begin
        found_v = found_v;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one alu8bitsHDL among NREQ requesters: round-robin grant, S1 operand
// register, S2 result register (grant-to-result latency 2, one op per cycle).
// Optional feature macro: ALU_ARB_ILLEGAL_CHECK_EN adds rsp_err for opcode 011.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] a_i,
  input  logic [NREQ*8-1:0] b_i,
  input  logic [NREQ*3-1:0] f_i,
  input  logic              hold,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_vld,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_y,
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
  output logic              rsp_err,
`endif
  output logic              busy
);

  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   gnt_idx_s;
  logic             xfer_s;
  logic [ALU_W-1:0] sel_a_s;
  logic [ALU_W-1:0] sel_b_s;
  logic [2:0]       sel_f_s;
  logic [ALU_W-1:0] alu_y_s;
  s1_t              s1_r;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr_arbiter (
    .req     (req),
    .en      (~hold),
    .ptr     (ptr_r),
    .gnt     (gnt),
    .gnt_idx (gnt_idx_s)
  );

  // gnt is only ever set on a requesting bit, so any grant is a transfer.
  assign xfer_s = |gnt;

  // One-hot operand mux driven by the grant vector.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    sel_f_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_a_s = a_i[k*8 +: 8];
        sel_b_s = b_i[k*8 +: 8];
        sel_f_s = f_i[k*3 +: 3];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  // Round-robin pointer: moves just past the granted index, frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      if (gnt_idx_s == IDW'(NREQ-1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= gnt_idx_s + IDW'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Issue stage: capture the granted operation; operands hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= '0;
    end else if (xfer_s) begin
      s1_r.vld <= 1'b1;
      s1_r.id  <= ID_MAX_W'(gnt_idx_s);
      s1_r.a   <= sel_a_s;
      s1_r.b   <= sel_b_s;
      s1_r.f   <= sel_f_s;
    end else begin
      s1_r.vld <= 1'b0;
    end
  end

  alu8bitsHDL u_alu (
    .a (s1_r.a),
    .b (s1_r.b),
    .f (s1_r.f),
    .y (alu_y_s)
  );

  // Result stage: pulse rsp_vld per issued op; rsp_y keeps its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
      rsp_y   <= 8'h00;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
      rsp_err <= 1'b0;
`endif
    end else begin
      rsp_vld <= s1_r.vld;
      rsp_id  <= IDW'(s1_r.id);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
      rsp_err <= s1_r.vld & ~alu_op_legal(s1_r.f);
      if (s1_r.vld) begin
        rsp_y <= alu_op_legal(s1_r.f) ? alu_y_s : 8'h00;
      end else begin
        rsp_y <= rsp_y;
      end
`else
      if (s1_r.vld) begin
        rsp_y <= alu_y_s;
      end else begin
        rsp_y <= rsp_y;
      end
`endif
    end
  end

  assign busy = s1_r.vld | rsp_vld;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter (NREQ=4); expected values computed by hand.
module tb_alu_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] a_i;
  logic [NREQ*8-1:0] b_i;
  logic [NREQ*3-1:0] f_i;
  logic              hold;
  logic [NREQ-1:0]   gnt;
  logic              rsp_vld;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_y;
  logic              busy;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
  logic              rsp_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_rr_arbiter #(.NREQ(NREQ)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a_i     (a_i),
    .b_i     (b_i),
    .f_i     (f_i),
    .hold    (hold),
    .gnt     (gnt),
    .rsp_vld (rsp_vld),
    .rsp_id  (rsp_id),
    .rsp_y   (rsp_y),
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    .rsp_err (rsp_err),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
    a_i[k*8 +: 8] = a;
    b_i[k*8 +: 8] = b;
    f_i[k*3 +: 3] = f;
  endtask

  // Lone request from k: grant now, nothing next cycle, result two cycles later.
  task automatic single_op(input int k, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] f, input logic [7:0] exp_y, input logic exp_err);
    logic [NREQ-1:0] one_v;
    one_v = 4'b0001;
    set_op(k, a, b, f);
    req = one_v << k;
    #1;
    check_eq("single_gnt", gnt, one_v << k);
    tick();
    req = 4'b0000;
    #1;
    check_eq("single_vld_n1", rsp_vld, 1'b0);
    check_eq("single_busy_n1", busy, 1'b1);
    tick();
    check_eq("single_vld", rsp_vld, 1'b1);
    check_eq("single_id", rsp_id, k);
    check_eq("single_y", rsp_y, exp_y);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    check_eq("single_err", rsp_err, exp_err);
`else
    if (exp_err) $display("note: rsp_err not built in this configuration");
`endif
  endtask

  task automatic drain();
    req = 4'b0000;
    tick();
    tick();
    tick();
    check_eq("drain_vld", rsp_vld, 1'b0);
    check_eq("drain_busy", busy, 1'b0);
  endtask

  logic [7:0] rr_y [4] = '{8'h00, 8'hFF, 8'hAA, 8'hAA};
  logic [2:0] rr_f [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    req   = 4'b1111;
    a_i   = '0;
    b_i   = '0;
    f_i   = '0;
    for (int k = 0; k < NREQ; k++) set_op(k, 8'hAA, 8'h55, rr_f[k]);

    // Reset state
    tick();
    tick();
    check_eq("rst_vld", rsp_vld, 1'b0);
    check_eq("rst_id", rsp_id, 2'd0);
    check_eq("rst_y", rsp_y, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_gnt", gnt, 4'b0001);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    check_eq("rst_err", rsp_err, 1'b0);
`endif
    rst_n = 1'b1;

    // Round-robin with all four requesting
    for (int c = 0; c < 8; c++) begin
      #1;
      check_eq("rr_gnt", gnt, 4'b0001 << (c % 4));
      if (c >= 2) begin
        check_eq("rr_vld", rsp_vld, 1'b1);
        check_eq("rr_id", rsp_id, (c - 2) % 4);
        check_eq("rr_y", rsp_y, rr_y[(c - 2) % 4]);
      end else begin
        check_eq("rr_vld_early", rsp_vld, 1'b0);
      end
      tick();
    end
    drain();

    // Single requester 2, ptr is 0 here
    single_op(2, 8'h6C, 8'h7E, 3'b010, 8'hEA, 1'b0);
    single_op(2, 8'h6C, 8'h7E, 3'b110, 8'hEE, 1'b0);
    single_op(2, 8'h6C, 8'h7E, 3'b111, 8'h01, 1'b0);

    // Hold: ptr is 3, requesters 0 and 1 hold AND / OR of AA,55
    req = 4'b0011;
    #1;
    check_eq("hold_pre_gnt0", gnt, 4'b0001);
    tick();
    check_eq("hold_pre_gnt1", gnt, 4'b0010);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) hold = 1'b1;
      #1;
      check_eq("hold_gnt", gnt, 4'b0000);
      check_eq("hold_busy", busy, (i < 2) ? 1'b1 : 1'b0);
      if (i == 0) begin
        check_eq("hold_rsp0_id", rsp_id, 2'd0);
        check_eq("hold_rsp0_y", rsp_y, 8'h00);
      end
      if (i == 1) begin
        check_eq("hold_rsp1_id", rsp_id, 2'd1);
        check_eq("hold_rsp1_y", rsp_y, 8'hFF);
      end
      check_eq("hold_vld", rsp_vld, (i < 2) ? 1'b1 : 1'b0);
      tick();
    end
    hold = 1'b0;
    #1;
    check_eq("hold_release_gnt", gnt, 4'b0001);
    tick();
    check_eq("hold_release_gnt2", gnt, 4'b0010);
    tick();
    drain();

    // Reset mid-operation: ptr is 2, grant to 0 then reset
    req = 4'b0001;
    #1;
    check_eq("midrst_gnt", gnt, 4'b0001);
    tick();
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    check_eq("midrst_vld_slot", rsp_vld, 1'b0);
    tick();
    check_eq("midrst_vld_after", rsp_vld, 1'b0);
    req = 4'b0011;
    #1;
    check_eq("midrst_ptr0", gnt, 4'b0001);
    req = 4'b0000;
    tick();

`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    single_op(0, 8'h12, 8'h34, 3'b011, 8'h00, 1'b1);
    single_op(0, 8'h12, 8'h34, 3'b010, 8'h46, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
